ff_fifo_stream_reader: RTL and testbench
========================================

FF_FIFO_STREAM_READER -- requirements
Module: ff_fifo_stream_reader

Interface
REQ-001 Parameter: width, default 8, data word width in bits.
REQ-002 Parameter: stat_width, default 16, width of the statistics counter.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: fifo_empty  input  1  empty flag from the upstream FIFO.
REQ-006 Port: fifo_read_data  input  width  upstream FIFO head word; valid whenever fifo_empty is 0.
REQ-007 Port: fifo_pop  output  1  pops the upstream FIFO head at the next rising edge.
REQ-008 Port: out_valid  output  1  downstream word valid.
REQ-009 Port: out_ready  input  1  downstream accepts the word.
REQ-010 Port: out_data  output  width  downstream word; driven from a register.
REQ-011 Port: word_count  output  stat_width  number of delivered words; present only when FIFO_READER_STATS_EN is defined.

Function
REQ-012 The block SHALL hold a 2-entry buffer (head, skid) with occupancy state EMPTY, ONE or TWO.
REQ-013 The block SHALL compute fifo_pop = ~fifo_empty & (state != TWO) & ~rst, with no combinational path from out_ready.
REQ-014 On a cycle where fifo_pop is 1, the block SHALL capture fifo_read_data into the buffer: into head if head is free after this cycle's drain, otherwise into skid.
REQ-015 A drain SHALL occur when out_valid & out_ready; on drain, skid (if occupied) moves to head.
REQ-016 State transitions SHALL follow these rules, where load = fifo_pop and drain as defined in REQ-015.
  - EMPTY: on load, go to ONE.
  - ONE: on load & ~drain, go to TWO; on drain & ~load, go to EMPTY; otherwise stay in ONE.
  - TWO: on drain, go to ONE; load cannot occur in TWO.
REQ-017 out_valid SHALL be 1 exactly when state is ONE or TWO, and out_data SHALL equal head.
REQ-018 Latency: a word presented while in EMPTY SHALL appear on out_valid/out_data at the next cycle.
REQ-019 With fifo_empty held at 0 and out_ready held at 1, the block SHALL sustain one word per cycle.
REQ-020 Word order SHALL be preserved; no word SHALL be lost or duplicated.
REQ-021 While out_valid is 1 and out_ready is 0, out_data SHALL stay stable.
REQ-022 The block SHALL never pop while fifo_empty is 1 (underflow impossible by construction).

Reset
REQ-023 On rst assertion, the state SHALL become EMPTY and out_valid SHALL become 0 asynchronously.
REQ-024 While rst is high, fifo_pop SHALL be 0 and word_count SHALL be 0.
REQ-025 Buffer data registers SHALL need no reset; out_data is don't-care while out_valid is 0.
REQ-026 Reset asserted mid-stream SHALL discard buffered words; the first pop after release SHALL occur no earlier than the first rising edge after deassertion.

Configuration
REQ-027 When FIFO_READER_STATS_EN is defined, word_count SHALL increment by 1 on every drain and wrap modulo 2^stat_width.
REQ-028 When FIFO_READER_STATS_EN is undefined, the word_count port and its counter SHALL be absent, with no other behavioural change.

Structure
REQ-029 Package ff_fifo_reader_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and the default stat_width constant.
REQ-030 The block SHALL be a single module with no sub-module; the statistics counter is inline under the macro.

Verification
REQ-031 Reset release with the FIFO holding 0xA5, out_ready=1 -> fifo_pop=1 on the first cycle; out_valid=1 with out_data=0xA5 on the next cycle.
REQ-032 Stream 0x01..0x10 with out_ready=1 continuously -> 16 consecutive valid cycles, in order, one pop per cycle.
REQ-033 out_ready=0 with 3 words available -> exactly 2 pops, state TWO, fifo_pop=0; raising out_ready delivers all 3 words in order.
REQ-034 Random out_ready (50%) over 1000 words -> scoreboard matches with no loss or duplication, and no fifo_pop while fifo_empty=1.
REQ-035 Assert rst while in TWO -> out_valid drops immediately and fifo_pop=0; after release, delivery resumes from the next upstream word.
REQ-036 With FIFO_READER_STATS_EN defined and stat_width=4, 17 drains -> word_count=1 (wrap verified).

Source files
------------

// File: rtl/ff_fifo_reader_pkg.sv
// ff_fifo_reader_pkg
// Shared definitions for the FIFO stream reader:
//   state_t            - buffer occupancy (EMPTY, ONE, TWO)
//   STAT_WIDTH_DEFAULT - default width of the delivered-word counter
package ff_fifo_reader_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int STAT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/ff_fifo_stream_reader.sv
// ff_fifo_stream_reader
// Pulls words from an upstream show-ahead FIFO and presents them on a
// registered valid/ready stream. A two-entry buffer (head + skid) lets
// fifo_pop be computed without any combinational path from out_ready,
// while still sustaining one word per cycle.
//
// Handshake: a word transfers downstream on every rising edge where
// out_valid & out_ready are both 1. Once out_valid is 1 it stays 1 and
// out_data stays stable until that transfer happens.
//
// Ports:
//   clk            - clock, all state updates on rising edge
//   rst            - asynchronous active-high reset
//   fifo_empty     - upstream FIFO empty flag
//   fifo_read_data - upstream head word, valid while fifo_empty is 0
//   fifo_pop       - pops the upstream head at the next rising edge
//   out_valid      - downstream word valid
//   out_ready      - downstream accepts the word
//   out_data       - downstream word (registered)
//   word_count     - delivered-word counter, only with FIFO_READER_STATS_EN
//   dbg_state      - current buffer occupancy state, for observation
//
// Build option: define FIFO_READER_STATS_EN to add the word_count port
// and its wrapping counter.
module ff_fifo_stream_reader
    import ff_fifo_reader_pkg::*;
#(
    parameter int width      = 8,
    parameter int stat_width = STAT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [width-1:0]      fifo_read_data,
    output logic                  fifo_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [width-1:0]      out_data,
`ifdef FIFO_READER_STATS_EN
    output logic [stat_width-1:0] word_count,
`endif
    output state_t                dbg_state
);

    state_t           state;
    state_t           state_next;
    logic [width-1:0] head;
    logic [width-1:0] skid;
    logic             load;
    logic             drain;
    logic             head_free;

    // Pop decision depends only on registered state and the upstream flag.
    assign fifo_pop  = ~fifo_empty & (state != TWO) & ~rst;
    assign load      = fifo_pop;
    assign out_valid = (state != EMPTY);
    assign drain     = out_valid & out_ready;
    assign out_data  = head;
    assign dbg_state = state;

    // Head is available to the incoming word if it is empty now, or holds
    // the only word and that word leaves this cycle.
    assign head_free = (state == EMPTY) | ((state == ONE) & drain);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (load) state_next = ONE;
            end
            ONE: begin
                if (load && !drain)      state_next = TWO;
                else if (drain && !load) state_next = EMPTY;
            end
            TWO: begin
                // No load is possible here: fifo_pop is gated off in TWO.
                if (drain) state_next = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Data registers carry no reset; their contents only matter while
    // out_valid is 1, which the state register already guards.
    always_ff @(posedge clk) begin
        if ((state == TWO) && drain) begin
            head <= skid;
        end else if (load && head_free) begin
            head <= fifo_read_data;
        end
        if (load && !head_free) begin
            skid <= fifo_read_data;
        end
    end

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (drain) begin
            word_count <= word_count + 1'b1;
        end
    end
`else
    // Counter width is unused without the statistics option.
    logic unused_stat_width;
    assign unused_stat_width = stat_width[0];
`endif

endmodule

// File: tb/tb_ff_fifo_stream_reader.sv
// tb_ff_fifo_stream_reader
// Self-checking bench for ff_fifo_stream_reader. The upstream FIFO is a
// queue of words; the reference model treats the DUT as a store of at most
// two popped-but-undelivered words (exp_q), from which expected pop, valid
// and data values follow directly.
// Build option: FIFO_READER_STATS_EN also checks word_count (stat_width=4).
module tb_ff_fifo_stream_reader;
    import ff_fifo_reader_pkg::*;

    localparam int W      = 8;
    localparam int STAT_W = 4;

    logic          clk;
    logic          rst;
    logic          fifo_empty;
    logic [W-1:0]  fifo_read_data;
    logic          fifo_pop;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    state_t        dbg_state;
`ifdef FIFO_READER_STATS_EN
    logic [STAT_W-1:0] word_count;
`endif

    ff_fifo_stream_reader #(.width(W), .stat_width(STAT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_pop       (fifo_pop),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
`ifdef FIFO_READER_STATS_EN
        .word_count     (word_count),
`endif
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] src_q[$];   // words still in the upstream FIFO
    logic [W-1:0] exp_q[$];   // words popped, not yet delivered
    int n_tests;
    int n_fail;
    int delivered;
    int pops;
    int drains;               // drains since last reset
    logic         obs_pop;
    logic         obs_valid;
    logic [W-1:0] obs_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs (already at the negedge), check, update model.
    task automatic drive_and_check(input bit avail, input bit rdy);
        bit exp_pop;
        fifo_empty     = !(avail && src_q.size() > 0);
        fifo_read_data = fifo_empty ? W'($urandom) : src_q[0];
        out_ready      = rdy;
        #1;
        exp_pop = !fifo_empty && (exp_q.size() < 2) && !rst;
        obs_pop   = fifo_pop;
        obs_valid = out_valid;
        obs_data  = out_data;
        chk("fifo_pop", fifo_pop, exp_pop);
        chk("no_underflow", fifo_pop & fifo_empty, 0);
        chk("out_valid", out_valid, exp_q.size() > 0);
        if (out_valid && exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
        if (exp_q.size() > 0 && rdy) begin
            void'(exp_q.pop_front());
            delivered++;
            drains++;
        end
        if (exp_pop) begin
            exp_q.push_back(src_q.pop_front());
            pops++;
        end
    endtask

    task automatic step(input bit avail, input bit rdy);
        @(negedge clk);
        drive_and_check(avail, rdy);
    endtask

    // Assert reset mid-cycle; outputs must drop without waiting for a clock.
    task automatic assert_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid_async", out_valid, 0);
        chk("rst_pop", fifo_pop, 0);
        exp_q.delete();
        drains = 0;
`ifdef FIFO_READER_STATS_EN
        chk("rst_word_count", word_count, 0);
`endif
        step(1, 1);
        step(1, 1);
    endtask

    task automatic release_reset(input bit avail, input bit rdy);
        @(negedge clk);
        rst = 1'b0;
        drive_and_check(avail, rdy);
    endtask

    task automatic run_until_delivered(input int target, input bit rand_mode);
        int budget;
        budget = 0;
        while (delivered < target && budget < 20000) begin
            if (rand_mode) step($urandom_range(0, 3) != 0, $urandom_range(0, 1));
            else           step(1, 1);
            budget++;
        end
        chk("deliver_timeout", delivered >= target, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0; n_fail = 0; delivered = 0; pops = 0; drains = 0;
        rst = 1'b1; fifo_empty = 1'b1; fifo_read_data = '0; out_ready = 1'b0;

        // Reset release with 0xA5 waiting upstream.
        src_q.push_back(8'hA5);
        step(1, 1);
        chk("reset_state", dbg_state, EMPTY);
        chk("reset_valid", out_valid, 0);
        release_reset(1, 1);
        chk("first_pop", obs_pop, 1);
        step(1, 1);
        chk("first_valid", obs_valid, 1);
        chk("first_data", obs_data, 8'hA5);
        step(1, 1);

        // Streaming 0x01..0x10 at full rate.
        delivered = 0; pops = 0;
        for (int i = 1; i <= 16; i++) src_q.push_back(W'(i));
        for (int i = 0; i < 17; i++) step(1, 1);
        chk("stream_pops", pops, 16);
        chk("stream_delivered", delivered, 16);
        step(1, 1);

        // Back-pressure with 3 words: exactly two are taken.
        delivered = 0; pops = 0;
        src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("bp_pops", pops, 2);
        chk("bp_state", dbg_state, TWO);
        chk("bp_pop_low", obs_pop, 0);
        run_until_delivered(3, 0);
        chk("bp_src_drained", src_q.size(), 0);
        step(1, 1);

        // Reset while holding two words.
        src_q.push_back(8'h44); src_q.push_back(8'h55); src_q.push_back(8'h66);
        for (int i = 0; i < 3; i++) step(1, 0);
        chk("pre_rst_state", dbg_state, TWO);
        assert_reset();
        chk("rst_state", dbg_state, EMPTY);
        release_reset(1, 1);
        chk("resume_pop", obs_pop, 1);
        step(1, 1);
        chk("resume_data", obs_data, 8'h66);
        step(1, 1);

`ifdef FIFO_READER_STATS_EN
        // 17 drains into a 4-bit counter wraps to 1.
        assert_reset();
        release_reset(0, 1);
        delivered = 0;
        for (int i = 0; i < 17; i++) src_q.push_back(W'($urandom));
        run_until_delivered(17, 0);
        step(0, 1);
        chk("wc_wrap", word_count, 1);
`endif

        // Randomized traffic: 1000 words, random availability and ready.
        delivered = 0;
        for (int i = 0; i < 1000; i++) src_q.push_back(W'($urandom));
        run_until_delivered(1000, 1);
        for (int i = 0; i < 4; i++) step(0, 1);
        chk("rand_idle", out_valid, 0);
`ifdef FIFO_READER_STATS_EN
        chk("rand_word_count", word_count, drains % (1 << STAT_W));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
